// File: rtl/mips_mul_div_pkg.sv
// mips_mul_div_pkg: shared types and constants for the MIPS multiply/divide path
package mips_mul_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // Quotient reported for a zero divisor (MIPS leaves it unpredictable; we pick all-ones)
    localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: divider request/result bundle
//   load, dividend, divisor            request side (master drives)
//   quotient, remainder, busy, done,
//   div_by_zero                        result side (slave drives)
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             load;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output load, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  load, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider_iter_counter.sv
// div_iter_counter: loadable down-counter with terminal flag
//   clk, rst_n  clock, synchronous active-low reset
//   load, init  parallel load (wins over en)
//   en          decrement enable, ignored once count reaches 0
//   count       current value
//   K           combinational terminal flag, count==1
module div_iter_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] init,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             K
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb count_d = load ? init : (en && count_q != '0) ? count_q - CNT_W'(1) : count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
    assign K     = (count_q == CNT_W'(1));
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring shift-subtract divider, one iteration per clock
//   clk, rst_n  clock, synchronous active-low reset
//   bus         seq_divider_if slave: load/dividend/divisor in,
//               quotient/remainder/busy/done/div_by_zero out
module seq_divider
    import mips_mul_div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH_DEFAULT,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    seq_divider_if.slave bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d, d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH+1:0] sh, t;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic             neg, k, start;
    logic [CNT_W-1:0] count;

    // Partial remainder shifted left with the next dividend bit; the extra top bit
    // makes the borrow of the trial subtraction explicit.
    assign sh     = {a_q, q_q[WIDTH-1]};
    assign t      = sh - {2'b00, d_q};
    assign neg    = t[WIDTH+1];
    assign a_step = neg ? sh[WIDTH:0] : t[WIDTH:0];
    assign q_step = {q_q[WIDTH-2:0], ~neg};
    assign start  = (state_q == S_IDLE) && bus.load && (bus.divisor != '0);

    div_iter_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .init  (CNT_W'(WIDTH)),
        .en    ((state_q == S_RUN) && (count != '0)),
        .count (count),
        .K     (k)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_RUN;
                a_d     = '0;
                q_d     = bus.dividend;
                d_d     = bus.divisor;
            end else if (bus.load) begin
                state_d = S_DONE;
                quo_d   = '1;
                rem_d   = bus.dividend;
                dbz_d   = 1'b1;
            end
        end else if (state_q == S_RUN) begin
            a_d = a_step;
            q_d = q_step;
            if (k) begin
                state_d = S_DONE;
                quo_d   = q_step;
                rem_d   = a_step[WIDTH-1:0];
                dbz_d   = 1'b0;
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboarded bench for seq_divider at WIDTH=8 and WIDTH=32
module tb_seq_divider;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb8[$];
    exp_t sb32[$];

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(8))  b8 ();
    seq_divider_if #(.WIDTH(32)) b32 ();

    seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

    // Drives a one-cycle load on the 8-bit DUT; returns at the negedge after the load edge.
    task automatic issue8(input logic [7:0] n, input logic [7:0] d, input bit push);
        exp_t e;
        e.z = (d == 0);
        e.q = (d == 0) ? 32'hFF : 32'(n / d);
        e.r = (d == 0) ? 32'(n) : 32'(n % d);
        if (push) sb8.push_back(e);
        b8.load = 1'b1;
        b8.dividend = n;
        b8.divisor = d;
        @(negedge clk);
        b8.load = 1'b0;
    endtask

    // Counts edges from the load edge until done is seen (0 = timed out).
    task automatic wait_done8(input int limit, output int edges, output int busy_cyc);
        edges = 0;
        busy_cyc = 0;
        for (int k = 0; k < limit; k++) begin
            if (b8.busy) busy_cyc++;
            if (b8.done) begin
                edges = k + 1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        b8.load = 1'b0; b8.dividend = '0; b8.divisor = '0;
        b32.load = 1'b0; b32.dividend = '0; b32.divisor = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({b8.quotient, b8.remainder, b8.busy, b8.done, b8.div_by_zero} !== 19'd0) begin
            fails++;
            $display("FAIL reset8: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
                     b8.quotient, b8.remainder, b8.busy, b8.done, b8.div_by_zero);
        end
        tests++;
        if ({b32.quotient, b32.remainder, b32.busy, b32.done, b32.div_by_zero} !== 67'd0) begin
            fails++;
            $display("FAIL reset32: got q=%h r=%h busy=%b done=%b, want all 0",
                     b32.quotient, b32.remainder, b32.busy, b32.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int edges, busy_cyc;
        exp_t e;
        issue8(8'd100, 8'd7, 1'b1);
        wait_done8(20, edges, busy_cyc);
        e = sb8.pop_front();
        tests++;
        if (edges != 9) begin
            fails++;
            $display("FAIL basic_latency: got %0d edges, want 9", edges);
        end
        tests++;
        if (busy_cyc != 9) begin
            fails++;
            $display("FAIL basic_busy: got %0d busy cycles, want 9", busy_cyc);
        end
        tests++;
        if (b8.quotient !== e.q[7:0] || b8.remainder !== e.r[7:0] || b8.div_by_zero !== e.z
            || e.q != 14 || e.r != 2) begin
            fails++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0",
                     b8.quotient, b8.remainder, b8.div_by_zero);
        end
        @(negedge clk);
        tests++;
        if (b8.done !== 1'b0 || b8.busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_pulse: got done=%b busy=%b after completion, want 0/0", b8.done, b8.busy);
        end
    endtask

    task automatic test_edge_operands;
        logic [7:0] ns[3] = '{8'd255, 8'd5, 8'd200};
        logic [7:0] ds[3] = '{8'd1, 8'd9, 8'd200};
        int edges, busy_cyc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue8(ns[i], ds[i], 1'b1);
            wait_done8(20, edges, busy_cyc);
            e = sb8.pop_front();
            tests++;
            if (edges != 9 || b8.quotient !== e.q[7:0] || b8.remainder !== e.r[7:0] || b8.div_by_zero !== 1'b0) begin
                fails++;
                $display("FAIL edge_%0d/%0d: got q=%0d r=%0d edges=%0d, want q=%0d r=%0d edges=9",
                         ns[i], ds[i], b8.quotient, b8.remainder, edges, e.q, e.r);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_by_zero;
        int edges, busy_cyc;
        exp_t e;
        issue8(8'd37, 8'd0, 1'b1);
        wait_done8(20, edges, busy_cyc);
        e = sb8.pop_front();
        tests++;
        if (edges != 1 || b8.quotient !== 8'hFF || b8.remainder !== 8'd37 || b8.div_by_zero !== e.z || !e.z) begin
            fails++;
            $display("FAIL dbz: got q=%h r=%0d dbz=%b edges=%0d, want q=ff r=37 dbz=1 edges=1",
                     b8.quotient, b8.remainder, b8.div_by_zero, edges);
        end
        @(negedge clk);
        tests++;
        if (b8.div_by_zero !== 1'b1 || b8.quotient !== 8'hFF) begin
            fails++;
            $display("FAIL dbz_hold: got dbz=%b q=%h, want dbz=1 q=ff held", b8.div_by_zero, b8.quotient);
        end
        issue8(8'd10, 8'd3, 1'b1);
        wait_done8(20, edges, busy_cyc);
        e = sb8.pop_front();
        tests++;
        if (b8.quotient !== e.q[7:0] || b8.remainder !== e.r[7:0] || b8.div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b, want q=3 r=1 dbz=0",
                     b8.quotient, b8.remainder, b8.div_by_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_load;
        int edges, busy_cyc, extra;
        exp_t e;
        issue8(8'd100, 8'd7, 1'b1);
        @(negedge clk);
        issue8(8'd50, 8'd5, 1'b0);
        wait_done8(20, edges, busy_cyc);
        e = sb8.pop_front();
        tests++;
        if (edges != 7 || b8.quotient !== e.q[7:0] || b8.remainder !== e.r[7:0]) begin
            fails++;
            $display("FAIL ignored_load: got q=%0d r=%0d after %0d more edges, want q=14 r=2 after 7",
                     b8.quotient, b8.remainder, edges);
        end
        @(negedge clk);
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            if (b8.done || b8.busy) extra++;
            @(negedge clk);
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL ignored_no_second: got %0d busy/done cycles, want 0", extra);
        end
    endtask

    task automatic test_reset_mid_op;
        int edges, busy_cyc, extra;
        exp_t e;
        issue8(8'd100, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({b8.quotient, b8.remainder, b8.busy, b8.done, b8.div_by_zero} !== 19'd0) begin
            fails++;
            $display("FAIL reset_mid: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     b8.quotient, b8.remainder, b8.busy, b8.done, b8.div_by_zero);
        end
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (b8.done || b8.busy) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL reset_no_done: got %0d busy/done cycles, want 0", extra);
        end
        issue8(8'd9, 8'd2, 1'b1);
        wait_done8(20, edges, busy_cyc);
        e = sb8.pop_front();
        tests++;
        if (edges != 9 || b8.quotient !== e.q[7:0] || b8.remainder !== e.r[7:0]) begin
            fails++;
            $display("FAIL reset_fresh: got q=%0d r=%0d edges=%0d, want q=4 r=1 edges=9",
                     b8.quotient, b8.remainder, edges);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int edges, busy_cyc, gap;
        exp_t e;
        sb8.push_back('{q: 32'd6, r: 32'd2, z: 1'b0});
        sb8.push_back('{q: 32'd6, r: 32'd2, z: 1'b0});
        b8.load = 1'b1;
        b8.dividend = 8'd20;
        b8.divisor = 8'd3;
        @(negedge clk);
        wait_done8(20, edges, busy_cyc);
        e = sb8.pop_front();
        tests++;
        if (edges != 9 || b8.quotient !== e.q[7:0] || b8.remainder !== e.r[7:0]) begin
            fails++;
            $display("FAIL b2b_first: got q=%0d r=%0d edges=%0d, want q=6 r=2 edges=9",
                     b8.quotient, b8.remainder, edges);
        end
        @(negedge clk);
        gap = 0;
        for (int k = 1; k < 30; k++) begin
            if (b8.done) begin
                gap = k;
                break;
            end
            @(negedge clk);
        end
        b8.load = 1'b0;
        e = sb8.pop_front();
        tests++;
        if (gap != 10 || b8.quotient !== e.q[7:0] || b8.remainder !== e.r[7:0]) begin
            fails++;
            $display("FAIL b2b_spacing: got done gap %0d q=%0d r=%0d, want gap 10 q=6 r=2",
                     gap, b8.quotient, b8.remainder);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_soak32;
        logic [31:0] n, d;
        exp_t e;
        int edges, bad_lat, bad_res, bad_pulse;
        bad_lat = 0; bad_res = 0; bad_pulse = 0;
        for (int i = 0; i < 1500; i++) begin
            n = $urandom;
            d = $urandom >> $urandom_range(0, 31);
            if (d == 0) d = 32'd1;
            sb32.push_back('{q: n / d, r: n % d, z: 1'b0});
            b32.load = 1'b1;
            b32.dividend = n;
            b32.divisor = d;
            @(negedge clk);
            b32.load = 1'b0;
            edges = 0;
            for (int k = 0; k < 40; k++) begin
                if (b32.done) begin
                    edges = k + 1;
                    break;
                end
                @(negedge clk);
            end
            e = sb32.pop_front();
            if (edges != 33) begin
                bad_lat++;
                if (bad_lat <= 3) $display("FAIL soak_latency: op %0d got %0d edges, want 33", i, edges);
            end
            if (b32.quotient !== e.q || b32.remainder !== e.r || b32.div_by_zero !== 1'b0
                || 64'(b32.quotient) * 64'(d) + 64'(b32.remainder) != 64'(n) || b32.remainder >= d) begin
                bad_res++;
                if (bad_res <= 3)
                    $display("FAIL soak_result: %h/%h got q=%h r=%h, want q=%h r=%h",
                             n, d, b32.quotient, b32.remainder, e.q, e.r);
            end
            @(negedge clk);
            if (b32.done !== 1'b0) begin
                bad_pulse++;
                if (bad_pulse <= 3) $display("FAIL soak_pulse: op %0d done=%b one cycle later, want 0", i, b32.done);
            end
        end
        tests += 3;
        if (bad_lat != 0) fails++;
        if (bad_res != 0) fails++;
        if (bad_pulse != 0) fails++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_edge_operands;
        test_div_by_zero;
        test_ignored_load;
        test_reset_mid_op;
        test_back_to_back;
        test_soak32;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
